alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback with an in-order store queue
// Non-stores write the register file one cycle after acceptance; stores queue for memory.
module alu_writeback #(
  parameter int SQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_addr,
  input  logic        in_is_store,
  input  logic [1:0]  in_size,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_gnt,
  output logic [4:0]  sq_count,
  output logic        sq_empty
);

  localparam int         PW     = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(SQ_DEPTH);

  logic [63:0]   sq_addr_q [SQ_DEPTH];
  logic [63:0]   sq_data_q [SQ_DEPTH];
  logic [1:0]    sq_size_q [SQ_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [63:0]   rf_wdata_q, rf_wdata_d;

  logic          accept, push, pop;
  logic [63:0]   masked_data;

  // Full is judged on the registered count only, so a pop never opens the slot the same cycle.
  assign in_ready = (count_q < DEPTH5);
  assign accept   = in_valid && in_ready;
  assign push     = accept && in_is_store;
  assign sq_empty = (count_q == 5'd0);
  assign mem_req  = !sq_empty;
  assign pop      = mem_req && mem_gnt;

  assign sq_count  = count_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign mem_addr  = sq_addr_q[rd_ptr_q];
  assign mem_wdata = sq_data_q[rd_ptr_q];
  assign mem_size  = sq_size_q[rd_ptr_q];

  always_comb begin
    masked_data = in_data;
    case (in_size)
      2'd0:    masked_data = {56'd0, in_data[7:0]};
      2'd1:    masked_data = {48'd0, in_data[15:0]};
      2'd2:    masked_data = {32'd0, in_data[31:0]};
      default: masked_data = in_data;
    endcase
  end

  // Pointers are PW bits wide over a power-of-two depth, so increment wraps DEPTH-1 to 0.
  always_comb begin
    rf_we_d    = accept && !in_is_store && (in_rd != 5'd0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = in_rd;
      rf_wdata_d = in_data;
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + {4'd0, push} - {4'd0, pop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 64'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= 5'd0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy is governed entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      sq_addr_q[wr_ptr_q] <= in_addr;
      sq_data_q[wr_ptr_q] <= masked_data;
      sq_size_q[wr_ptr_q] <= in_size;
    end
  end

endmodule
